// File: rtl/tank_cmd_pkg.sv
// Shared command codes and repeat-FSM states for the tank command path.
// The game engine decoder uses the same definitions.
package tank_cmd_pkg;

    localparam logic [2:0] CmdUp    = 3'd0;
    localparam logic [2:0] CmdDown  = 3'd1;
    localparam logic [2:0] CmdLeft  = 3'd2;
    localparam logic [2:0] CmdRight = 3'd3;
    localparam logic [2:0] CmdFire  = 3'd4;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StRepeat
    } rep_state_e;

    // Lowest set bit wins when several press pulses coincide.
    function automatic logic [1:0] first_dir(input logic [3:0] pulse);
        if (pulse[0]) begin
            return 2'd0;
        end else if (pulse[1]) begin
            return 2'd1;
        end else if (pulse[2]) begin
            return 2'd2;
        end else begin
            return 2'd3;
        end
    endfunction

endpackage

// File: rtl/tank_cmd_sched_if.sv
// Command stream handshake between the scheduler (master) and the game engine (slave).
interface tank_cmd_sched_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_code;

    modport master (
        output cmd_valid,
        output cmd_code,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_code,
        output cmd_ready
    );

endinterface

// File: rtl/cmd_fifo.sv
// Small synchronous command FIFO; a push on a full FIFO is accepted when a pop
// happens in the same cycle. Read data reads as zero while empty.
module cmd_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [2:0]               push_data,
    input  logic                     pop,
    output logic [2:0]               pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [2:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_q, wr_d;
    logic [PtrW-1:0] rd_q, rd_d;
    logic [PtrW:0]   count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (PtrW+1)'(DEPTH));
    assign count    = count_q;
    assign pop_data = empty ? 3'd0 : mem_q[rd_q];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (do_push) begin
            wr_d = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_data;
        end
    end

endmodule

// File: rtl/tank_cmd_sched.sv
// Turns debounced direction/fire inputs into a buffered stream of game commands,
// with direction auto-repeat, fire cooldown and a one-entry collision buffer.
module tank_cmd_sched
    import tank_cmd_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_RATE   = 10_000_000,
    parameter int unsigned FIRE_COOLDOWN = 50_000_000,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          RSTN,
    input  logic [3:0]                    dir_level,
    input  logic [3:0]                    dir_pulse,
    input  logic                          fire_pulse,
    input  logic                          pause,
    tank_cmd_sched_if.master              cmd,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          fire_blocked
);

    localparam int unsigned MaxCnt = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RcntW  = $clog2(MaxCnt);
    localparam int unsigned CoolW  = $clog2(FIRE_COOLDOWN + 1);

    rep_state_e       state_q, state_d;
    logic [1:0]       trk_q, trk_d;
    logic [RcntW-1:0] rcnt_q, rcnt_d;
    logic [CoolW-1:0] cool_q, cool_d;
    logic             pend_valid_q, pend_valid_d;
    logic [2:0]       pend_code_q, pend_code_d;
    logic             overflow_q, overflow_d;

    logic             dir_ev;
    logic [2:0]       dir_code;
    logic             fire_ev;
    logic             push;
    logic [2:0]       push_code;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [2:0]       head_code;

    // Repeat FSM: press pulses always retarget; release drops back to idle.
    always_comb begin
        state_d  = state_q;
        trk_d    = trk_q;
        rcnt_d   = rcnt_q;
        dir_ev   = 1'b0;
        dir_code = {1'b0, trk_q};
        if (pause) begin
            state_d = StIdle;
            rcnt_d  = '0;
        end else if (|dir_pulse) begin
            dir_ev   = 1'b1;
            dir_code = {1'b0, first_dir(dir_pulse)};
            trk_d    = first_dir(dir_pulse);
            state_d  = StHold;
            rcnt_d   = '0;
        end else if (state_q != StIdle && !dir_level[trk_q]) begin
            state_d = StIdle;
            rcnt_d  = '0;
        end else begin
            case (state_q)
                StHold: begin
                    if (rcnt_q == RcntW'(REPEAT_DELAY - 1)) begin
                        dir_ev  = 1'b1;
                        state_d = StRepeat;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                StRepeat: begin
                    if (rcnt_q == RcntW'(REPEAT_RATE - 1)) begin
                        dir_ev = 1'b1;
                        rcnt_d = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                default: begin
                    rcnt_d = '0;
                end
            endcase
        end
    end

    // Cooldown keeps running through pause; the load happens even if the FIFO drops the write.
    always_comb begin
        fire_ev = fire_pulse && !pause && (cool_q == '0);
        if (fire_ev) begin
            cool_d = CoolW'(FIRE_COOLDOWN);
        end else if (cool_q != '0) begin
            cool_d = cool_q - 1'b1;
        end else begin
            cool_d = cool_q;
        end
    end

    // One FIFO write per cycle: FIRE, then pending, then a fresh direction event.
    always_comb begin
        push         = 1'b0;
        push_code    = CmdUp;
        pend_valid_d = pend_valid_q;
        pend_code_d  = pend_code_q;
        if (pause) begin
            pend_valid_d = 1'b0;
        end else if (fire_ev) begin
            push      = 1'b1;
            push_code = CmdFire;
            if (dir_ev) begin
                pend_valid_d = 1'b1;
                pend_code_d  = dir_code;
            end
        end else if (pend_valid_q) begin
            push         = 1'b1;
            push_code    = pend_code_q;
            pend_valid_d = dir_ev;
            if (dir_ev) begin
                pend_code_d = dir_code;
            end
        end else if (dir_ev) begin
            push      = 1'b1;
            push_code = dir_code;
        end
    end

    assign cmd.cmd_valid = !fifo_empty && !pause;
    assign cmd.cmd_code  = head_code;
    assign pop           = cmd.cmd_valid && cmd.cmd_ready;
    assign overflow_d    = overflow_q || (push && fifo_full && !pop);
    assign overflow      = overflow_q;
    assign fire_blocked  = (cool_q != '0);

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q      <= StIdle;
            trk_q        <= 2'd0;
            rcnt_q       <= '0;
            cool_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_code_q  <= 3'd0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            trk_q        <= trk_d;
            rcnt_q       <= rcnt_d;
            cool_q       <= cool_d;
            pend_valid_q <= pend_valid_d;
            pend_code_q  <= pend_code_d;
            overflow_q   <= overflow_d;
        end
    end

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (RSTN),
        .push      (push),
        .push_data (push_code),
        .pop       (pop),
        .pop_data  (head_code),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: doc/tank_cmd_sched.md
# tank_cmd_sched

Command scheduler between the input debouncer and the tank game engine. It turns debounced direction levels and pulses plus fire pulses into a stream of discrete game commands. Held directions auto-repeat, fire is rate-limited by a cooldown, and commands are buffered in a small FIFO drained through a valid/ready handshake. One instance serves one player's control set.

## Interface
Parameters:
- REPEAT_DELAY, 25_000_000: cycles from initial press to first auto-repeat (≥2).
- REPEAT_RATE, 10_000_000: cycles between subsequent auto-repeats (≥2).
- FIRE_COOLDOWN, 50_000_000: cycles after an accepted FIRE during which further fire pulses are dropped (≥1).
- FIFO_DEPTH, 4: command FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  system clock; single clock domain.
- RSTN  in  1  asynchronous, active-low reset.
- dir_level  in  4  debounced direction levels: [0] UP, [1] DOWN, [2] LEFT, [3] RIGHT.
- dir_pulse  in  4  one-cycle press pulses, same bit order.
- fire_pulse  in  1  one-cycle fire press pulse.
- pause  in  1  game pause, level.
- cmd_ready  in  1  engine accepts the head command.
- cmd_valid  out  1  head command valid.
- cmd_code  out  3  head command code.
- fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set when any command is dropped on a full FIFO.
- fire_blocked  out  1  high while the cooldown counter is nonzero.

## Operation
- Command codes: UP=0, DOWN=1, LEFT=2, RIGHT=3, FIRE=4. Codes 5–7 are unused and never emitted.
- Repeat FSM, states IDLE, HOLD, REPEAT. Registers: tracked direction `trk` (2 bits) and counter `rcnt`.
  - Any dir_pulse bit (lowest index wins if several): generate that direction event, `trk` set to it, go HOLD, `rcnt` cleared. Applies from any state, including a retarget.
  - HOLD: `rcnt` increments. At `rcnt == REPEAT_DELAY-1`, generate a `trk` event, go REPEAT, clear `rcnt`.
  - REPEAT: at `rcnt == REPEAT_RATE-1`, generate a `trk` event and clear `rcnt`.
  - HOLD/REPEAT: if dir_level[trk] is 0 and there is no pulse this cycle, go IDLE with no event.
- Fire: a fire_pulse with cooldown 0 generates a FIRE event and loads cooldown with FIRE_COOLDOWN. A fire_pulse with cooldown ≠ 0 is dropped; overflow is not affected. Cooldown decrements to 0 and saturates there.
- Write arbitration: the FIFO takes one write per cycle.
  - FIRE has priority.
  - A direction event that collides with FIRE goes to a 1-entry pending register and is written the next cycle.
  - A new direction event arriving while pending is occupied overwrites pending.
  - Pending has priority over a new direction event in the same cycle; that new event overwrites pending.
- FIFO full on write: the write is dropped and overflow is set. If the FIFO is full and cmd_valid&cmd_ready occur in the same cycle, the write is accepted.
- pause=1:
  - No events are generated; pulses are ignored.
  - FSM goes to IDLE and pending is cleared.
  - Cooldown keeps counting.
  - cmd_valid is forced 0 and FIFO contents are retained.
- overflow clears only on reset.

## Timing
- Reset (async assert, sync release use): FSM IDLE, `rcnt`=0, cooldown=0, pending empty, FIFO empty, cmd_valid=0, cmd_code=0, fifo_count=0, overflow=0, fire_blocked=0.
- Event at cycle n is written at the edge ending cycle n. With an empty FIFO and pause=0, cmd_valid=1 in cycle n+1 with the matching cmd_code.
- A pending event is written one cycle later, so its cmd_valid appears at n+2.
- Handshake: a pop occurs when cmd_valid&cmd_ready are sampled high at the edge. cmd_code is stable while cmd_valid=1 and not popped. cmd_code is 0 when the FIFO is empty.
- Hold timing: press pulse at cycle p. Events occur at p, p+REPEAT_DELAY, p+REPEAT_DELAY+REPEAT_RATE·k.
- fire_blocked rises the cycle after an accepted FIRE and stays high for FIRE_COOLDOWN cycles.
- Mid-operation reset clears everything immediately; in-flight commands are lost.

## Structure
- Package `tank_cmd_pkg`: the 3-bit command code constants (UP/DOWN/LEFT/RIGHT/FIRE) and the repeat-FSM state enum. These are shared with the game engine decoder.
- Sub-module `cmd_fifo`: synchronous FIFO (DEPTH parameter, 3-bit data, push/pop, full/empty/count, simultaneous push+pop when full accepted).
- FSM, cooldown, pending register and arbitration live in the top level.

## Test plan
Parameters for all scenarios: REPEAT_DELAY=10, REPEAT_RATE=4, FIRE_COOLDOWN=8, FIFO_DEPTH=4; cmd_ready=1 unless stated.
- Tap: dir_pulse=0001 with dir_level high 3 cycles, released → exactly one UP; cmd_valid=1 one cycle after the pulse; FSM back to IDLE.
- Hold: UP pulse at cycle 0, level held 30 cycles → UP pops at cycles 1, 11, 15, 19, 23, 27; none after release.
- Fire cooldown: fire_pulse at 0, 3, 9 → FIRE accepted at 0 and 9 only; fire_blocked high cycles 1–8.
- Collision: fire_pulse and dir_pulse=0100 at the same cycle n → FIRE at n+1, LEFT at n+2.
- Overflow: cmd_ready=0, 5 distinct pulses → fifo_count=4, overflow=1. Raise cmd_ready → pops in order: first four codes; overflow stays 1.
- Pause/reset: pause during HOLD → no repeats and cmd_valid=0; after unpause, queued entries drain. RSTN low mid-hold → all outputs take reset values asynchronously.
